// File: rtl/spike_rate_decoder_if.sv
// Result channel of the spike rate decoder: valid/ready handshake plus the
// per-window payload (packed counts, argmax winner, tie and saturation flags).
interface spike_rate_decoder_if #(
  parameter int unsigned CW = 6
);
  logic            result_valid;
  logic            result_ready;
  logic [4*CW-1:0] count_bus;
  logic [1:0]      winner;
  logic            tie;
  logic            saturated;

  // Producer side: the decoder drives the result and samples ready.
  modport master (
    output result_valid,
    output count_bus,
    output winner,
    output tie,
    output saturated,
    input  result_ready
  );

  // Consumer side: readout/control logic.
  modport slave (
    input  result_valid,
    input  count_bus,
    input  winner,
    input  tie,
    input  saturated,
    output result_ready
  );
endinterface

// File: rtl/spike_rate_decoder.sv
// Spike rate decoder: counts rising edges on four spike lines over a
// programmable window and publishes the counts, the most active channel and
// tie/saturation flags through a valid/ready result channel.
module spike_rate_decoder #(
  parameter int unsigned CW = 6,
  parameter int unsigned WW = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 enable_i,
  input  logic [WW-1:0]        window_len_i,
  input  logic [3:0]           spike_i,
  spike_rate_decoder_if.master res,
  output logic                 overrun_o,
  output logic                 busy_o
);

  localparam logic [CW-1:0] CntMax = '1;

  typedef enum logic [0:0] {StIdle, StCount} state_e;

  state_e                 state_q, state_d;
  logic [WW-1:0]          win_q, win_d;
  logic [3:0]             spike_q;
  logic [3:0][CW-1:0]     cnt_q, cnt_d;
  logic [3:0]             sat_q, sat_d;

  logic                   valid_q, valid_d;
  logic [3:0][CW-1:0]     res_cnt_q, res_cnt_d;
  logic [1:0]             winner_q, winner_d;
  logic                   tie_q, tie_d;
  logic                   res_sat_q, res_sat_d;
  logic                   overrun_q, overrun_d;

  logic [3:0]             ev;
  logic [3:0][CW-1:0]     cnt_inc;
  logic [3:0]             sat_inc;
  logic [1:0]             best_idx;
  logic [CW-1:0]          best_val;
  logic [2:0]             num_max;
  logic                   tie_c;
  logic                   win_end;
  logic                   can_load;

  // Rising-edge detect against last cycle's sample; history runs in every state.
  assign ev = spike_i & ~spike_q;

  // Per-channel saturating increment with this cycle's event folded in.
  always_comb begin
    cnt_inc = cnt_q;
    sat_inc = sat_q;
    for (int i = 0; i < 4; i++) begin
      if (ev[i]) begin
        if (cnt_q[i] == CntMax) begin
          sat_inc[i] = 1'b1;
        end else begin
          cnt_inc[i] = cnt_q[i] + CW'(1);
        end
      end
    end
  end

  // Argmax over the final counts; strict '>' keeps the lowest index on ties.
  always_comb begin
    best_idx = 2'd0;
    best_val = cnt_inc[0];
    for (int i = 1; i < 4; i++) begin
      if (cnt_inc[i] > best_val) begin
        best_val = cnt_inc[i];
        best_idx = 2'(i);
      end
    end
    num_max = 3'd0;
    for (int i = 0; i < 4; i++) begin
      if (cnt_inc[i] == best_val) begin
        num_max = num_max + 3'd1;
      end
    end
    tie_c = (num_max > 3'd1);
  end

  assign win_end  = (state_q == StCount) && (win_q == '0);
  // A finished window may overwrite the result only if the slot is free or
  // being drained on this very edge.
  assign can_load = !valid_q || res.result_ready;

  // Next-state logic for the window FSM, counters and result registers.
  always_comb begin
    state_d   = state_q;
    win_d     = win_q;
    cnt_d     = cnt_q;
    sat_d     = sat_q;
    valid_d   = valid_q & ~res.result_ready;
    res_cnt_d = res_cnt_q;
    winner_d  = winner_q;
    tie_d     = tie_q;
    res_sat_d = res_sat_q;
    overrun_d = overrun_q;

    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        sat_d = '0;
        if (enable_i && (window_len_i != '0)) begin
          state_d = StCount;
          win_d   = window_len_i - WW'(1);
        end
      end
      StCount: begin
        if (win_end) begin
          if (can_load) begin
            valid_d   = 1'b1;
            res_cnt_d = cnt_inc;
            winner_d  = best_idx;
            tie_d     = tie_c;
            res_sat_d = |sat_inc;
          end else begin
            overrun_d = 1'b1;
          end
          cnt_d = '0;
          sat_d = '0;
          // Back-to-back windows pick up whatever window_len is now.
          if (enable_i && (window_len_i != '0)) begin
            win_d = window_len_i - WW'(1);
          end else begin
            state_d = StIdle;
          end
        end else if (!enable_i) begin
          // Abort: partial window is discarded without a result.
          state_d = StIdle;
          cnt_d   = '0;
          sat_d   = '0;
        end else begin
          cnt_d = cnt_inc;
          sat_d = sat_inc;
          win_d = win_q - WW'(1);
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Window FSM, counters and spike history.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      win_q   <= '0;
      spike_q <= '0;
      cnt_q   <= '0;
      sat_q   <= '0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      spike_q <= spike_i;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
    end
  end

  // Result registers and the sticky overrun flag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q   <= 1'b0;
      res_cnt_q <= '0;
      winner_q  <= 2'd0;
      tie_q     <= 1'b0;
      res_sat_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      res_cnt_q <= res_cnt_d;
      winner_q  <= winner_d;
      tie_q     <= tie_d;
      res_sat_q <= res_sat_d;
      overrun_q <= overrun_d;
    end
  end

  assign res.result_valid = valid_q;
  assign res.count_bus    = res_cnt_q;
  assign res.winner       = winner_q;
  assign res.tie          = tie_q;
  assign res.saturated    = res_sat_q;
  assign overrun_o        = overrun_q;
  assign busy_o           = (state_q == StCount);

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Directed bench for spike_rate_decoder: hand-computed windows covering
// counting, edge detection, saturation, backpressure, abort, reset and
// window-length sampling.
module tb_spike_rate_decoder;

  logic       clk_i;
  logic       rst_ni;
  logic       enable_i;
  logic [7:0] window_len_i;
  logic [3:0] spike_i;
  logic       overrun_o;
  logic       busy_o;

  logic [3:0] pat [256];
  int         total;
  int         bad;

  spike_rate_decoder_if #(.CW(6)) ifc ();

  spike_rate_decoder #(
    .CW(6),
    .WW(8)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .enable_i    (enable_i),
    .window_len_i(window_len_i),
    .spike_i     (spike_i),
    .res         (ifc),
    .overrun_o   (overrun_o),
    .busy_o      (busy_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] pk(input int c0, input int c1, input int c2, input int c3);
    return {6'(c3), 6'(c2), 6'(c1), 6'(c0)};
  endfunction

  task automatic chk_res(input string tag, input logic [23:0] cnts, input int win,
                         input int tie, input int sat);
    check({tag, "_valid"}, 32'(ifc.result_valid), 1);
    check({tag, "_counts"}, 32'(ifc.count_bus), 32'(cnts));
    check({tag, "_winner"}, 32'(ifc.winner), win);
    check({tag, "_tie"}, 32'(ifc.tie), tie);
    check({tag, "_sat"}, 32'(ifc.saturated), sat);
  endtask

  task automatic clr_pat();
    for (int k = 0; k < 256; k++) pat[k] = 4'h0;
  endtask

  // One IDLE cycle with spikes low, then the edge into COUNT.
  task automatic start(input int len);
    enable_i     = 1'b1;
    window_len_i = 8'(len);
    spike_i      = 4'h0;
    tick();
  endtask

  // Window cycles from..to; on cycle last_k enable takes last_en.
  task automatic run(input int from, input int to, input int last_k, input logic last_en);
    for (int k = from; k <= to; k++) begin
      spike_i  = pat[k];
      enable_i = (k == last_k) ? last_en : 1'b1;
      tick();
    end
  endtask

  task automatic consume(input string tag);
    ifc.result_ready = 1'b1;
    tick();
    ifc.result_ready = 1'b0;
    check(tag, 32'(ifc.result_valid), 0);
  endtask

  initial begin
    total            = 0;
    bad              = 0;
    rst_ni           = 1'b0;
    enable_i         = 1'b0;
    window_len_i     = 8'd0;
    spike_i          = 4'h0;
    ifc.result_ready = 1'b0;
    clr_pat();
    #3;
    check("rst_valid", 32'(ifc.result_valid), 0);
    check("rst_counts", 32'(ifc.count_bus), 0);
    check("rst_winner", 32'(ifc.winner), 0);
    check("rst_tie", 32'(ifc.tie), 0);
    check("rst_ovr", 32'(overrun_o), 0);
    check("rst_busy", 32'(busy_o), 0);
    tick();
    rst_ni = 1'b1;
    tick();

    // 1: basic window of 10 with single-cycle spikes.
    clr_pat();
    pat[0] = 4'b0001; pat[3] = 4'b0001; pat[5] = 4'b0100; pat[9] = 4'b0001;
    start(10);
    check("t1_busy", 32'(busy_o), 1);
    run(0, 8, 9, 1'b0);
    check("t1_notyet", 32'(ifc.result_valid), 0);
    run(9, 9, 9, 1'b0);
    chk_res("t1", pk(3, 0, 1, 0), 0, 0, 0);
    check("t1_idle", 32'(busy_o), 0);
    consume("t1_consume");

    // 2: held level counts once, toggling counts each rise.
    clr_pat();
    for (int k = 2; k <= 7; k++) pat[k] = pat[k] | 4'b0010;
    for (int k = 1; k <= 7; k += 2) pat[k] = pat[k] | 4'b1000;
    start(10);
    run(0, 9, 9, 1'b0);
    chk_res("t2", pk(0, 1, 0, 4), 3, 0, 0);
    consume("t2_consume");
    // ch0 high across a window boundary, back-to-back windows of 4.
    clr_pat();
    pat[2] = 4'b0001; pat[3] = 4'b0001;
    start(4);
    run(0, 3, 3, 1'b1);
    chk_res("t2a", pk(1, 0, 0, 0), 0, 0, 0);
    check("t2a_busy", 32'(busy_o), 1);
    clr_pat();
    pat[0] = 4'b0001; pat[1] = 4'b0001;
    run(0, 2, 3, 1'b0);
    ifc.result_ready = 1'b1;
    run(3, 3, 3, 1'b0);
    ifc.result_ready = 1'b0;
    chk_res("t2b", pk(0, 0, 0, 0), 0, 1, 0);
    consume("t2b_consume");

    // 3: saturation at 63, then a clean window with the reloaded length.
    clr_pat();
    for (int k = 0; k < 200; k += 2) pat[k] = 4'b0100;
    start(200);
    run(0, 198, 199, 1'b1);
    window_len_i = 8'd20;
    run(199, 199, 199, 1'b1);
    chk_res("t3a", pk(0, 0, 63, 0), 2, 0, 1);
    clr_pat();
    for (int k = 0; k < 20; k += 2) pat[k] = 4'b0100;
    ifc.result_ready = 1'b1;
    run(0, 0, 19, 1'b1);
    ifc.result_ready = 1'b0;
    check("t3_drained", 32'(ifc.result_valid), 0);
    run(1, 19, 19, 1'b0);
    chk_res("t3b", pk(0, 0, 10, 0), 2, 0, 0);
    consume("t3b_consume");

    // 4: backpressure across two windows of 8 drops the second.
    clr_pat();
    pat[2] = 4'b0010;
    start(8);
    run(0, 7, 7, 1'b1);
    chk_res("t4a", pk(0, 1, 0, 0), 1, 0, 0);
    check("t4a_ovr", 32'(overrun_o), 0);
    clr_pat();
    pat[1] = 4'b1000; pat[4] = 4'b1000;
    run(0, 7, 7, 1'b0);
    chk_res("t4b", pk(0, 1, 0, 0), 1, 0, 0);
    check("t4b_ovr", 32'(overrun_o), 1);
    consume("t4_consume");
    check("t4_ovr_sticky", 32'(overrun_o), 1);

    // 5: abort mid-window produces nothing.
    clr_pat();
    pat[1] = 4'b0001;
    start(10);
    run(0, 3, 9, 1'b1);
    enable_i = 1'b0;
    spike_i  = 4'h0;
    tick();
    check("t5_abort_busy", 32'(busy_o), 0);
    repeat (12) tick();
    check("t5_abort_valid", 32'(ifc.result_valid), 0);
    // Asynchronous reset with a result pending and a window in flight.
    clr_pat();
    pat[0] = 4'b0100;
    start(4);
    run(0, 3, 3, 1'b1);
    chk_res("t5r", pk(0, 0, 1, 0), 2, 0, 0);
    run(0, 1, 3, 1'b1);
    rst_ni = 1'b0;
    #1;
    check("t5_rst_valid", 32'(ifc.result_valid), 0);
    check("t5_rst_counts", 32'(ifc.count_bus), 0);
    check("t5_rst_winner", 32'(ifc.winner), 0);
    check("t5_rst_tie", 32'(ifc.tie), 0);
    check("t5_rst_sat", 32'(ifc.saturated), 0);
    check("t5_rst_ovr", 32'(overrun_o), 0);
    check("t5_rst_busy", 32'(busy_o), 0);
    enable_i = 1'b0;
    spike_i  = 4'h0;
    tick();
    rst_ni = 1'b1;
    tick();
    // All-zero window: winner 0 with tie.
    clr_pat();
    start(3);
    run(0, 2, 2, 1'b0);
    chk_res("t5z", pk(0, 0, 0, 0), 0, 1, 0);
    consume("t5z_consume");

    // 6: zero length never starts.
    enable_i     = 1'b1;
    window_len_i = 8'd0;
    spike_i      = 4'h0;
    repeat (3) tick();
    check("t6_zero_busy", 32'(busy_o), 0);
    check("t6_zero_valid", 32'(ifc.result_valid), 0);
    enable_i = 1'b0;
    tick();
    // Length change mid-window applies only from the next window.
    clr_pat();
    pat[0] = 4'b0001;
    start(5);
    run(0, 1, 4, 1'b1);
    window_len_i = 8'd3;
    run(2, 3, 4, 1'b1);
    check("t6_len_held", 32'(ifc.result_valid), 0);
    run(4, 4, 4, 1'b1);
    chk_res("t6a", pk(1, 0, 0, 0), 0, 0, 0);
    check("t6a_busy", 32'(busy_o), 1);
    clr_pat();
    pat[1] = 4'b1000;
    ifc.result_ready = 1'b1;
    run(0, 0, 2, 1'b1);
    ifc.result_ready = 1'b0;
    check("t6_drained", 32'(ifc.result_valid), 0);
    run(1, 2, 2, 1'b0);
    chk_res("t6b", pk(0, 0, 0, 1), 3, 0, 0);
    check("t6b_busy", 32'(busy_o), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spike_rate_decoder.md
Name: spike_rate_decoder

Overview:
Reads spike trains produced by the LIF neuron network (three input-neuron spikes plus the output-neuron spike) and converts them back to numbers. Over a programmable observation window it counts spike events per channel, then presents the counts and the most active channel through a valid/ready result interface. It sits downstream of the neuron network and feeds the readout/control logic.

Parameters:
CW, 6, per-channel spike count width (counts saturate at 2^CW-1)
WW, 8, width of window_len and the internal window down-counter

Ports:
clk  input  1  system clock
reset  input  1  asynchronous active-low reset
enable  input  1  run windows while high; low returns to IDLE
window_len  input  WW  window length in cycles, sampled at each window start
spike_in  input  4  spike lines: [0..2] = neurons 1..3, [3] = output neuron
result_ready  input  1  consumer accepts result when high with result_valid
result_valid  output  1  result registers hold an unconsumed result
count_bus  output  4*CW  packed counts, channel i at [i*CW +: CW]
winner  output  2  index of highest count
tie  output  1  two or more channels share the maximum (includes all-zero)
saturated  output  1  at least one channel saturated in this result
overrun  output  1  sticky: a completed window was dropped due to backpressure
busy  output  1  high while in COUNT

Behaviour:
- Reset (async, reset=0): state IDLE; all counters, window counter and spike history cleared; result_valid=0, count_bus=0, winner=0, tie=0, saturated=0, overrun=0, busy=0. Reset mid-window discards the partial window.
- Spike event = rising edge: spike_in[i]=1 and previous-cycle sample=0. The history register updates every cycle in every state, so a level high across a window boundary is not recounted. A line held high for N cycles counts 1.
- FSM is two states, IDLE and COUNT:
  - IDLE -> COUNT when enable=1 and window_len!=0. On that edge, load down-counter = window_len-1 and clear the channel counters.
  - window_len=0 stays in IDLE.
  - IDLE edges are not counted.
- COUNT:
  - Each cycle, each channel counter adds its event; increment at 2^CW-1 holds and sets the channel's sat bit.
  - Window = exactly window_len COUNT cycles, including an event on the last cycle.
- Window end (down-counter=0 in COUNT):
  - Final counts = counter + this cycle's event (saturating).
  - If result_valid=0 or result_ready=1 that cycle: load count_bus, winner, tie, saturated; result_valid=1 next cycle.
  - Otherwise the result is dropped, outputs are unchanged and overrun sets; overrun clears only on reset.
  - Counters and sat bits clear.
  - If enable=1: reload the down-counter from the current window_len (0 -> IDLE) and stay in COUNT; the next window starts the following cycle with no gap.
  - If enable=0: go to IDLE.
- enable=0 mid-window (not the end cycle): abort, go to IDLE, clear counters, produce no result.
- Handshake:
  - result_valid clears the cycle after result_valid & result_ready, unless a new result loads on that same edge, in which case it stays 1 with new data.
  - Outputs are stable while valid and not accepted.
- Latency: result_valid rises on the cycle after the last window cycle, i.e. window_len+1 cycles after the IDLE->COUNT edge.
- Winner:
  - Combinational argmax over the four final counts, registered with the result.
  - The lowest index wins ties.
  - tie=1 when the max is shared; all-zero gives winner=0, tie=1.
- busy=1 exactly while state=COUNT.

Test Plan:
1. window_len=10, enable pulse held. Single-cycle spikes on ch0 at window cycles 0,3,9 and ch2 at cycle 5 -> result_valid at cycle 11, counts {0:3, 1:0, 2:1, 3:0}, winner=0, tie=0.
2. ch1 held high for 6 cycles mid-window and ch3 toggled every other cycle (4 edges) -> ch1=1, ch3=4, winner=3. Also ch0 high across a window boundary -> counted once total.
3. CW=6, window_len=200, ch2 alternating every cycle (100 edges) -> count 63, saturated=1. Next window with 10 edges -> count 10, saturated=0.
4. result_ready=0 across two back-to-back 8-cycle windows -> first result held unchanged, overrun=1. Then assert ready -> result_valid drops next cycle (or reloads if coincident with a window end).
5. Abort and reset: enable drops at window cycle 4 of 10 -> no result_valid, busy=0 next cycle. Reset asserted mid-window -> all outputs 0 asynchronously. All counts zero -> winner=0, tie=1.
6. window_len=0 with enable=1 -> remains IDLE, busy=0. Change window_len mid-window -> takes effect only at the next window start.
